// File: rtl/aes_pkg.sv
// Shared AES constants, word/block types and the GF(2^8) doubling used for rcon.
package aes_pkg;

  localparam int unsigned AES_NK     = 4;
  localparam int unsigned AES_ROUNDS = 10;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned RNUM_W     = 4;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_EMIT = 1'b1;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Start/key input and round-key valid/ready stream of the key schedule.
interface aes_key_schedule_if;

  logic                   start;
  aes_pkg::block_t        key_in;
  logic                   busy;
  logic                   rk_valid;
  logic                   rk_ready;
  aes_pkg::block_t        round_key;
  logic [3:0]             round_num;
  logic                   done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, round_key, round_num, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, round_key, round_num, done
  );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte lookup.
module aes_sbox (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_data = SBOX[i_data];

endmodule

// File: rtl/aes_key_schedule.sv
// On-the-fly AES-128 key expansion: holds one round key and streams keys 0..NUM_ROUNDS
// over a valid/ready handshake.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic               clk,
  input  logic               reset,
  aes_key_schedule_if.slave  bus
);

  state_t              r_state, w_state_nxt;
  block_t              r_round_key, w_round_key_nxt;
  logic [RNUM_W-1:0]   r_round_num, w_round_num_nxt;
  logic [7:0]          r_rcon, w_rcon_nxt;
  logic                r_rk_valid, w_rk_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;

  logic                w_hs, w_last;
  word_t               w_w0, w_w1, w_w2, w_w3, w_rot, w_sub, w_t;
  word_t               w_n0, w_n1, w_n2, w_n3;

  assign w_hs   = r_rk_valid & bus.rk_ready;
  assign w_last = (r_round_num == RNUM_W'(NUM_ROUNDS));

  // Next-round-key datapath: RotWord -> SubWord -> rcon -> XOR chain
  assign {w_w0, w_w1, w_w2, w_w3} = r_round_key;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_data (w_rot[8*g +: 8]),
      .o_data (w_sub[8*g +: 8])
    );
  end

  assign w_t  = w_sub ^ {r_rcon, 24'h0};
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start)      w_state_nxt = ST_EMIT;
      ST_EMIT: if (w_hs && w_last) w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; a stall simply falls through to hold
  always_comb begin
    w_round_key_nxt = r_round_key;
    w_round_num_nxt = r_round_num;
    w_rcon_nxt      = r_rcon;
    w_done_nxt      = 1'b0;
    w_rk_valid_nxt  = (w_state_nxt == ST_EMIT);
    w_busy_nxt      = (w_state_nxt == ST_EMIT);
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_round_key_nxt = bus.key_in;
          w_round_num_nxt = '0;
          w_rcon_nxt      = RCON_INIT;
        end
      end
      ST_EMIT: begin
        if (w_hs && !w_last) begin
          w_round_key_nxt = {w_n0, w_n1, w_n2, w_n3};
          w_round_num_nxt = RNUM_W'(r_round_num + RNUM_W'(1));
          w_rcon_nxt      = xtime(r_rcon);
        end
        if (w_hs && w_last) w_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_round_key <= '0;
      r_round_num <= '0;
      r_rcon      <= RCON_INIT;
      r_rk_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_round_key <= w_round_key_nxt;
      r_round_num <= w_round_num_nxt;
      r_rcon      <= w_rcon_nxt;
      r_rk_valid  <= w_rk_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.round_key = r_round_key;
  assign bus.round_num = r_round_num;
  assign bus.rk_valid  = r_rk_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: known-answer round keys queued at start and
// compared at every valid cycle, for a full-length and a 3-round instance.
module tb_aes_key_schedule;
  import aes_pkg::*;

  typedef struct {
    logic [3:0] num;
    block_t     key;
  } exp_t;

  localparam block_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t ZERO_KEY = 128'h0;

  localparam block_t FIPS_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam block_t ZERO_RK [11] = '{
    128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  logic   clk = 1'b0;
  logic   reset, start_v, rk_ready_v, sel;
  block_t key_v;

  always #5 clk = ~clk;

  aes_key_schedule_if ifa ();
  aes_key_schedule_if ifb ();

  assign ifa.start    = start_v & ~sel;
  assign ifb.start    = start_v & sel;
  assign ifa.key_in   = key_v;
  assign ifb.key_in   = key_v;
  assign ifa.rk_ready = rk_ready_v;
  assign ifb.rk_ready = rk_ready_v;

  aes_key_schedule #(.NUM_ROUNDS(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  aes_key_schedule #(.NUM_ROUNDS(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  logic       obs_valid, obs_busy, obs_done;
  logic [3:0] obs_num;
  block_t     obs_key;

  assign obs_valid = sel ? ifb.rk_valid  : ifa.rk_valid;
  assign obs_busy  = sel ? ifb.busy      : ifa.busy;
  assign obs_done  = sel ? ifb.done      : ifa.done;
  assign obs_num   = sel ? ifb.round_num : ifa.round_num;
  assign obs_key   = sel ? ifb.round_key : ifa.round_key;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc;
  exp_t q[$];

  task automatic chk(input string tag, input block_t obs, input block_t exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chkb({tag, "_valid_a"}, ifa.rk_valid, 1'b0);
    chkb({tag, "_busy_a"},  ifa.busy,     1'b0);
    chkb({tag, "_done_a"},  ifa.done,     1'b0);
    chk ({tag, "_num_a"},   128'(ifa.round_num), 128'h0);
    chk ({tag, "_key_a"},   ifa.round_key, 128'h0);
    chkb({tag, "_valid_b"}, ifb.rk_valid, 1'b0);
    chkb({tag, "_done_b"},  ifb.done,     1'b0);
    chk ({tag, "_key_b"},   ifb.round_key, 128'h0);
  endtask

  task automatic push_sched(input bit zero, input int nr);
    exp_t e;
    for (int r = 0; r <= nr; r++) begin
      e.num = 4'(r);
      e.key = zero ? ZERO_RK[r] : FIPS_RK[r];
      q.push_back(e);
    end
  endtask

  // Pulse start for one edge, then scramble key_in since it must not be needed afterwards
  task automatic start_sched(input block_t k);
    key_v   = k;
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    key_v   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called on the negedge after the start edge; compares every valid cycle to the queue head
  task automatic consume(input int inj_round, input block_t inj_key, input int abort_round,
                         input bit rnd, output int cycles);
    int   budget;
    exp_t e;
    budget = 400;
    cycles = 0;
    while (q.size() > 0 && budget > 0) begin
      budget--;
      chkb("rk_valid",  obs_valid, 1'b1);
      chkb("busy",      obs_busy,  1'b1);
      chkb("done_low",  obs_done,  1'b0);
      chk ("round_num", 128'(obs_num), 128'(q[0].num));
      chk ("round_key", obs_key, q[0].key);
      if (abort_round >= 0 && int'(q[0].num) == abort_round) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        chk_reset("abort");
        return;
      end
      rk_ready_v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj_round >= 0 && int'(q[0].num) == inj_round) begin
        start_v = 1'b1;
        key_v   = inj_key;
      end
      if (rk_ready_v) e = q.pop_front();
      @(negedge clk);
      start_v = 1'b0;
      cycles++;
    end
    chk ("drained",      128'(q.size()), 128'h0);
    chkb("done_pulse",   obs_done,  1'b1);
    chkb("rk_valid_off", obs_valid, 1'b0);
    chkb("busy_off",     obs_busy,  1'b0);
    rk_ready_v = 1'b1;
  endtask

  initial begin
    sel        = 1'b0;
    reset      = 1'b1;
    start_v    = 1'b0;
    rk_ready_v = 1'b0;
    key_v      = '0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    reset = 1'b0;
    @(negedge clk);

    // FIPS key at full rate: 11 keys in 11 cycles, single-cycle done
    push_sched(1'b0, 10);
    start_sched(FIPS_KEY);
    consume(-1, '0, -1, 1'b0, cyc);
    chk("full_rate_cycles", 128'(cyc), 128'd11);
    @(negedge clk);
    chkb("done_once_fips", obs_done, 1'b0);

    // FIPS key with random backpressure
    push_sched(1'b0, 10);
    start_sched(FIPS_KEY);
    consume(-1, '0, -1, 1'b1, cyc);
    @(negedge clk);
    chkb("done_once_rnd", obs_done, 1'b0);

    // All-zero key
    push_sched(1'b1, 10);
    start_sched(ZERO_KEY);
    consume(-1, '0, -1, 1'b0, cyc);
    @(negedge clk);
    chkb("done_once_zero", obs_done, 1'b0);

    // start with a different key at round 4 must be ignored
    push_sched(1'b0, 10);
    start_sched(FIPS_KEY);
    consume(4, ZERO_KEY, -1, 1'b0, cyc);
    @(negedge clk);
    chkb("done_once_inj", obs_done, 1'b0);

    // reset at round 6, then a fresh FIPS schedule
    push_sched(1'b0, 10);
    start_sched(ZERO_KEY ^ FIPS_KEY);
    consume(-1, '0, 6, 1'b0, cyc);
    @(negedge clk);
    chkb("no_done_after_reset", obs_done, 1'b0);
    chkb("idle_after_reset", obs_valid, 1'b0);
    push_sched(1'b0, 10);
    start_sched(FIPS_KEY);
    consume(-1, '0, -1, 1'b1, cyc);
    @(negedge clk);

    // 3-round instance, with a back-to-back start in the done cycle
    sel = 1'b1;
    @(negedge clk);
    push_sched(1'b0, 3);
    start_sched(FIPS_KEY);
    consume(-1, '0, -1, 1'b0, cyc);
    chk("short_cycles", 128'(cyc), 128'd4);
    push_sched(1'b1, 3);
    start_sched(ZERO_KEY);
    consume(-1, '0, -1, 1'b1, cyc);
    @(negedge clk);
    chkb("short_done_once", obs_done, 1'b0);
    chkb("short_valid_off", obs_valid, 1'b0);
    chk ("short_last_num", 128'(obs_num), 128'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
